control_contador: RTL and testbench

CONTROL_CONTADOR -- requirements
Module: control_contador

---
 rtl/control_contador.sv | 163 ++++++++++++++++
 tb/tb_control_contador.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_contador.sv
// Up/down counter controller: button synchronizers, run/pause FSM,
// wrap or ping-pong limit handling and load/step pulse generation.
module control_contador #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_modo,
    input  logic       manual_sel,
    input  logic [3:0] sw_manual,
    input  logic [3:0] lim_inf,
    input  logic [3:0] lim_sup,
    input  logic [3:0] count_in,
    output logic       cnt_en,
    output logic       direccion,
    output logic       load,
    output logic [3:0] load_val,
    output logic [1:0] estado,
    output logic       modo,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSA = 2'b10,
        CARGA = 2'b11
    } state_t;

    localparam int CW = $clog2(SYNC_STAGES + 1);

    logic [2:0]    sync [SYNC_STAGES];
    logic [2:0]    sync_out;
    logic [2:0]    prev;
    logic [2:0]    armed;
    logic [2:0]    edge_det;
    logic [CW-1:0] settle_cnt;
    logic          settled;

    logic start_e;
    logic stop_e;
    logic modo_e;

    state_t     state;
    state_t     state_n;
    logic       cnt_en_n;
    logic       load_n;
    logic [3:0] load_val_n;
    logic       dir_n;
    logic       modo_n;
    logic       at_sup;
    logic       at_inf;

    assign sync_out = sync[SYNC_STAGES-1];
    assign settled  = (settle_cnt == CW'(SYNC_STAGES));
    assign edge_det = sync_out & ~prev & armed;
    assign start_e  = edge_det[0];
    assign stop_e   = edge_det[1];
    assign modo_e   = edge_det[2];

    // A button only arms once the chain has refilled after reset and
    // shows it released, so a button held through reset cannot fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync[i] <= '0;
            end
            prev       <= '0;
            armed      <= '0;
            settle_cnt <= '0;
        end else begin
            sync[0] <= {btn_modo, btn_stop, btn_start};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            prev  <= sync_out;
            armed <= armed | ({3{settled}} & ~sync_out);
            if (!settled) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    assign err    = (lim_inf > lim_sup);
    assign at_sup = (count_in >= lim_sup);
    assign at_inf = (count_in <= lim_inf);
    assign estado = state;

    always_comb begin
        state_n    = state;
        cnt_en_n   = 1'b0;
        load_n     = 1'b0;
        load_val_n = load_val;
        dir_n      = direccion;
        modo_n     = modo ^ modo_e;
        unique case (state)
            IDLE: begin
                if (start_e && !stop_e && !err) begin
                    state_n    = CARGA;
                    load_n     = 1'b1;
                    load_val_n = manual_sel ? sw_manual : lim_inf;
                    dir_n      = 1'b1;
                end
            end
            CARGA: begin
                state_n = RUN;
            end
            RUN: begin
                if (stop_e || err) begin
                    state_n = PAUSA;
                end else if (tick) begin
                    if (manual_sel) begin
                        load_n     = 1'b1;
                        load_val_n = sw_manual;
                    end else if (!modo && direccion && at_sup) begin
                        load_n     = 1'b1;
                        load_val_n = lim_inf;
                    end else if (!modo && !direccion && at_inf) begin
                        load_n     = 1'b1;
                        load_val_n = lim_sup;
                    end else if (modo && direccion && at_sup) begin
                        dir_n    = 1'b0;
                        cnt_en_n = 1'b1;
                    end else if (modo && !direccion && at_inf) begin
                        dir_n    = 1'b1;
                        cnt_en_n = 1'b1;
                    end else begin
                        cnt_en_n = 1'b1;
                    end
                end
            end
            PAUSA: begin
                if (stop_e) begin
                    state_n = IDLE;
                end else if (start_e && !err) begin
                    state_n = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt_en    <= 1'b0;
            load      <= 1'b0;
            load_val  <= 4'd0;
            direccion <= 1'b1;
            modo      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt_en    <= cnt_en_n;
            load      <= load_n;
            load_val  <= load_val_n;
            direccion <= dir_n;
            modo      <= modo_n;
        end
    end

endmodule

// File: tb/tb_control_contador.sv
// Bench for control_contador: tick decision table plus hand-written
// button, pause, error and reset sequences checked through a queue.
module tb_control_contador;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSA = 2'b10;
    localparam logic [1:0] S_CARGA = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_modo;
    logic       manual_sel;
    logic [3:0] sw_manual;
    logic [3:0] lim_inf;
    logic [3:0] lim_sup;
    logic [3:0] count_in;
    logic       cnt_en;
    logic       direccion;
    logic       load;
    logic [3:0] load_val;
    logic [1:0] estado;
    logic       modo;
    logic       err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] st;
        logic       ce;
        logic       ld;
        logic [3:0] lv;
        logic       dir;
        logic       md;
    } out_t;

    typedef struct {
        logic       ms;
        logic [3:0] sw;
        logic [3:0] li;
        logic [3:0] ls;
        logic [3:0] ci;
        logic       ce;
        logic       ld;
        logic [3:0] lv;
    } vec_t;

    out_t exp_q[$];
    vec_t vt[9];

    control_contador #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_modo  (btn_modo),
        .manual_sel(manual_sel),
        .sw_manual (sw_manual),
        .lim_inf   (lim_inf),
        .lim_sup   (lim_sup),
        .count_in  (count_in),
        .cnt_en    (cnt_en),
        .direccion (direccion),
        .load      (load),
        .load_val  (load_val),
        .estado    (estado),
        .modo      (modo),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input logic [3:0] act,
                       input logic [3:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", n, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] st, input logic ce,
                        input logic ld, input logic [3:0] lv,
                        input logic dir, input logic md);
        out_t o;
        o.st  = st;
        o.ce  = ce;
        o.ld  = ld;
        o.lv  = lv;
        o.dir = dir;
        o.md  = md;
        exp_q.push_back(o);
    endtask

    task automatic pop_check(input string tag);
        out_t o;
        if (exp_q.size() == 0) begin
            cmp({tag, " queue"}, 4'd0, 4'd1);
            return;
        end
        o = exp_q.pop_front();
        cmp({tag, " estado"}, {2'b0, estado}, {2'b0, o.st});
        cmp({tag, " cnt_en"}, {3'b0, cnt_en}, {3'b0, o.ce});
        cmp({tag, " load"}, {3'b0, load}, {3'b0, o.ld});
        cmp({tag, " load_val"}, load_val, o.lv);
        cmp({tag, " direccion"}, {3'b0, direccion}, {3'b0, o.dir});
        cmp({tag, " modo"}, {3'b0, modo}, {3'b0, o.md});
    endtask

    task automatic step(input string tag, input logic [1:0] st,
                        input logic ce, input logic ld,
                        input logic [3:0] lv, input logic dir,
                        input logic md);
        push(st, ce, ld, lv, dir, md);
        cyc();
        pop_check(tag);
    endtask

    // Two edges to cross the synchronizer; the caller's next step is the
    // edge on which the press acts.
    task automatic press(input logic s, input logic p, input logic m);
        btn_start = s;
        btn_stop  = p;
        btn_modo  = m;
        cyc();
        cyc();
    endtask

    task automatic rel();
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_modo  = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic do_tick(input string tag, input logic [3:0] ci,
                           input logic ce, input logic ld,
                           input logic [3:0] lv, input logic dir,
                           input logic md);
        count_in = ci;
        tick     = 1'b1;
        step(tag, S_RUN, ce, ld, lv, dir, md);
        tick     = 1'b0;
        step({tag, " after"}, S_RUN, 1'b0, 1'b0, lv, dir, md);
    endtask

    logic [3:0] lv_e;

    initial begin
        vt[0] = '{1'b0, 4'd0, 4'd2, 4'd5, 4'd3, 1'b1, 1'b0, 4'd0};
        vt[1] = '{1'b0, 4'd0, 4'd2, 4'd5, 4'd5, 1'b0, 1'b1, 4'd2};
        vt[2] = '{1'b0, 4'd0, 4'd2, 4'd5, 4'd9, 1'b0, 1'b1, 4'd2};
        vt[3] = '{1'b1, 4'd7, 4'd2, 4'd5, 4'd3, 1'b0, 1'b1, 4'd7};
        vt[4] = '{1'b1, 4'd7, 4'd2, 4'd5, 4'd5, 1'b0, 1'b1, 4'd7};
        vt[5] = '{1'b0, 4'd0, 4'd6, 4'd6, 4'd6, 1'b0, 1'b1, 4'd6};
        vt[6] = '{1'b0, 4'd0, 4'd0, 4'd15, 4'd14, 1'b1, 1'b0, 4'd0};
        vt[7] = '{1'b0, 4'd0, 4'd0, 4'd15, 4'd15, 1'b0, 1'b1, 4'd0};
        vt[8] = '{1'b0, 4'd0, 4'd3, 4'd9, 4'd0, 1'b1, 1'b0, 4'd0};

        rst        = 1'b0;
        tick       = 1'b0;
        btn_start  = 1'b0;
        btn_stop   = 1'b0;
        btn_modo   = 1'b0;
        manual_sel = 1'b0;
        sw_manual  = 4'd0;
        lim_inf    = 4'd2;
        lim_sup    = 4'd5;
        count_in   = 4'd0;

        repeat (2) @(negedge clk);
        push(S_IDLE, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        pop_check("reset");
        rst = 1'b1;
        repeat (4) cyc();
        step("idle", S_IDLE, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cmp("err low", {3'b0, err}, 4'd0);

        // Start, load of lim_inf, three steps, then wrap at lim_sup
        press(1'b1, 1'b0, 1'b0);
        step("carga", S_CARGA, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        btn_start = 1'b0;
        step("run", S_RUN, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        rel();
        for (int k = 0; k < 3; k++) begin
            do_tick("step", 4'(2 + k), 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
        end
        do_tick("wrap", 4'd5, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);

        lv_e = 4'd2;
        for (int i = 0; i < 9; i++) begin
            manual_sel = vt[i].ms;
            sw_manual  = vt[i].sw;
            lim_inf    = vt[i].li;
            lim_sup    = vt[i].ls;
            if (vt[i].ld) lv_e = vt[i].lv;
            do_tick($sformatf("vec%0d", i), vt[i].ci, vt[i].ce,
                    vt[i].ld, lv_e, 1'b1, 1'b0);
            manual_sel = 1'b0;
        end

        // Ping-pong between 0 and 3, then equal limits
        lim_inf = 4'd0;
        lim_sup = 4'd3;
        press(1'b0, 1'b0, 1'b1);
        step("modo on", S_RUN, 1'b0, 1'b0, lv_e, 1'b1, 1'b1);
        rel();
        do_tick("pp top", 4'd3, 1'b1, 1'b0, lv_e, 1'b0, 1'b1);
        do_tick("pp mid", 4'd2, 1'b1, 1'b0, lv_e, 1'b0, 1'b1);
        do_tick("pp bot", 4'd0, 1'b1, 1'b0, lv_e, 1'b1, 1'b1);
        lim_inf = 4'd5;
        lim_sup = 4'd5;
        do_tick("pp eq1", 4'd5, 1'b1, 1'b0, lv_e, 1'b0, 1'b1);
        do_tick("pp eq2", 4'd5, 1'b1, 1'b0, lv_e, 1'b1, 1'b1);
        lim_inf = 4'd0;
        lim_sup = 4'd3;
        do_tick("pp flip", 4'd3, 1'b1, 1'b0, lv_e, 1'b0, 1'b1);

        // Wrap mode counting down reloads lim_sup
        press(1'b0, 1'b0, 1'b1);
        step("modo off", S_RUN, 1'b0, 1'b0, lv_e, 1'b0, 1'b0);
        rel();
        do_tick("down wrap", 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        do_tick("down step", 4'd2, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while a step pulse is high
        press(1'b0, 1'b0, 1'b1);
        step("modo on2", S_RUN, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1);
        rel();
        count_in = 4'd2;
        tick     = 1'b1;
        step("pre rst", S_RUN, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1);
        tick = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        push(S_IDLE, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        pop_check("async rst");
        btn_start = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step("held start", S_IDLE, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        end
        rel();

        // Inverted limits block start and pause a running count
        lim_inf = 4'd9;
        lim_sup = 4'd4;
        #1;
        cmp("err high", {3'b0, err}, 4'd1);
        press(1'b1, 1'b0, 1'b0);
        step("err start", S_IDLE, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        rel();
        lim_inf = 4'd2;
        lim_sup = 4'd5;
        press(1'b1, 1'b0, 1'b0);
        step("carga2", S_CARGA, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        step("run2", S_RUN, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        rel();
        lim_inf = 4'd9;
        lim_sup = 4'd4;
        step("err pause", S_PAUSA, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        count_in = 4'd5;
        tick     = 1'b1;
        step("pause tick", S_PAUSA, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        tick = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        step("err resume", S_PAUSA, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        rel();
        lim_inf = 4'd2;
        lim_sup = 4'd5;
        press(1'b1, 1'b0, 1'b0);
        step("resume", S_RUN, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        rel();

        // Stop coinciding with tick, resume, and stop-over-start priority
        btn_stop = 1'b1;
        cyc();
        cyc();
        count_in = 4'd3;
        tick     = 1'b1;
        step("stop tick", S_PAUSA, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        tick = 1'b0;
        rel();
        press(1'b1, 1'b0, 1'b0);
        step("restart", S_RUN, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        rel();
        press(1'b1, 1'b1, 1'b0);
        step("both run", S_PAUSA, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        rel();
        press(1'b1, 1'b1, 1'b0);
        step("both pausa", S_IDLE, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        rel();
        press(1'b1, 1'b1, 1'b0);
        step("both idle", S_IDLE, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
        rel();
        press(1'b0, 1'b0, 1'b1);
        step("modo idle", S_IDLE, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1);
        rel();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
